// File: rtl/combiner.sv
// N-to-1 valid/ready join: buffers early lanes and emits one combined beat once
// every lane has contributed; live lanes pass through with zero latency.
module combiner #(
  parameter int NUM_S      = 2,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_S-1:0]            s_valid,
  output logic [NUM_S-1:0]            s_ready,
  input  logic [NUM_S*DATA_WIDTH-1:0] s_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [NUM_S*DATA_WIDTH-1:0] m_data,
  output logic                        busy,
  output logic [CNT_WIDTH-1:0]        beat_count
);

  logic [NUM_S-1:0]            held_q, held_d;
  logic [NUM_S*DATA_WIDTH-1:0] buf_q, buf_d;
  logic [CNT_WIDTH-1:0]        beat_count_q, beat_count_d;
  logic                        fire;

  always_comb begin
    m_valid = !reset & (&(held_q | s_valid));
    s_ready = reset ? '0 : ~held_q;
    busy    = |held_q;
    fire    = m_valid & m_ready;
    m_data  = '0;
    for (int unsigned i = 0; i < NUM_S; i++) begin
      m_data[i*DATA_WIDTH +: DATA_WIDTH] = held_q[i] ? buf_q[i*DATA_WIDTH +: DATA_WIDTH]
                                                     : s_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Fire wins over capture: a lane arriving in the firing cycle is consumed live.
  always_comb begin
    held_d       = held_q;
    buf_d        = buf_q;
    beat_count_d = beat_count_q;
    if (fire) begin
      held_d       = '0;
      beat_count_d = beat_count_q + CNT_WIDTH'(1);
    end else begin
      for (int unsigned i = 0; i < NUM_S; i++) begin
        if (s_valid[i] & s_ready[i]) begin
          held_d[i]                         = 1'b1;
          buf_d[i*DATA_WIDTH +: DATA_WIDTH] = s_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      held_q       <= '0;
      buf_q        <= '0;
      beat_count_q <= '0;
    end else begin
      held_q       <= held_d;
      buf_q        <= buf_d;
      beat_count_q <= beat_count_d;
    end
  end

  assign beat_count = beat_count_q;

endmodule

// File: tb/tb_combiner.sv
// Directed bench for combiner: default 2-lane instance plus a 4-bit counter instance for wrap.
module tb_combiner;

  logic        clk;
  logic        reset;
  logic [1:0]  s_valid, s_ready;
  logic [15:0] s_data, m_data;
  logic        m_valid, m_ready, busy;
  logic [15:0] beat_count;

  logic        w_reset;
  logic [1:0]  w_s_valid, w_s_ready;
  logic [15:0] w_s_data, w_m_data;
  logic        w_m_valid, w_m_ready, w_busy;
  logic [3:0]  w_beat_count;

  int errors = 0;
  int checks = 0;

  combiner u_dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy),
    .beat_count(beat_count)
  );

  combiner #(.NUM_S(2), .DATA_WIDTH(8), .CNT_WIDTH(4)) u_wrap (
    .clk(clk), .reset(w_reset), .s_valid(w_s_valid), .s_ready(w_s_ready), .s_data(w_s_data),
    .m_valid(w_m_valid), .m_ready(w_m_ready), .m_data(w_m_data), .busy(w_busy),
    .beat_count(w_beat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; s_valid = '0; s_data = '0; m_ready = 1'b0;
    w_reset = 1'b1; w_s_valid = '0; w_s_data = '0; w_m_ready = 1'b0;
    #1;
    chk("rst_mvalid", 32'(m_valid), 32'h0);
    chk("rst_sready", 32'(s_ready), 32'h0);
    tick(); tick();
    reset = 1'b0; w_reset = 1'b0;
    #1;
    chk("post_rst_sready", 32'(s_ready), 32'h3);
    chk("post_rst_busy", 32'(busy), 32'h0);
    chk("post_rst_count", 32'(beat_count), 32'h0);
    chk("post_rst_mvalid", 32'(m_valid), 32'h0);

    // Aligned pass-through
    s_valid = 2'b11; s_data = 16'hB2A1; m_ready = 1'b1;
    #1;
    chk("align_mvalid", 32'(m_valid), 32'h1);
    chk("align_mdata", 32'(m_data), 32'hB2A1);
    chk("align_sready", 32'(s_ready), 32'h3);
    tick();
    s_valid = '0;
    #1;
    chk("align_count", 32'(beat_count), 32'h1);
    chk("align_busy", 32'(busy), 32'h0);

    // Staggered arrival
    s_valid = 2'b01; s_data = 16'h0011;
    #1;
    chk("stag_c0_mvalid", 32'(m_valid), 32'h0);
    tick();
    s_valid = 2'b00; s_data = 16'hFFEE;
    #1;
    chk("stag_c1_sready", 32'(s_ready), 32'h2);
    chk("stag_c1_mvalid", 32'(m_valid), 32'h0);
    chk("stag_c1_busy", 32'(busy), 32'h1);
    tick();
    chk("stag_c2_sready", 32'(s_ready), 32'h2);
    chk("stag_c2_mvalid", 32'(m_valid), 32'h0);
    tick();
    s_valid = 2'b10; s_data = 16'h22EE;
    #1;
    chk("stag_c3_sready", 32'(s_ready), 32'h2);
    chk("stag_c3_mvalid", 32'(m_valid), 32'h1);
    chk("stag_c3_mdata", 32'(m_data), 32'h2211);
    tick();
    s_valid = '0;
    #1;
    chk("stag_c4_sready", 32'(s_ready), 32'h3);
    chk("stag_c4_busy", 32'(busy), 32'h0);
    chk("stag_c4_count", 32'(beat_count), 32'h2);

    // Backpressure
    s_valid = 2'b11; s_data = 16'h5566; m_ready = 1'b0;
    #1;
    chk("bp_mvalid0", 32'(m_valid), 32'h1);
    tick();
    s_data = 16'h7788;
    #1;
    chk("bp_sready", 32'(s_ready), 32'h0);
    chk("bp_busy", 32'(busy), 32'h1);
    chk("bp_mdata1", 32'(m_data), 32'h5566);
    chk("bp_mvalid1", 32'(m_valid), 32'h1);
    tick();
    s_data = 16'h99AA; s_valid = 2'b00;
    #1;
    chk("bp_mdata2", 32'(m_data), 32'h5566);
    chk("bp_mvalid2", 32'(m_valid), 32'h1);
    tick();
    chk("bp_count_hold", 32'(beat_count), 32'h2);
    m_ready = 1'b1;
    #1;
    chk("bp_fire_mvalid", 32'(m_valid), 32'h1);
    chk("bp_fire_mdata", 32'(m_data), 32'h5566);
    tick();
    chk("bp_count", 32'(beat_count), 32'h3);
    chk("bp_busy_after", 32'(busy), 32'h0);
    chk("bp_mvalid_after", 32'(m_valid), 32'h0);

    // Held lane ignores re-valid
    s_valid = 2'b01; s_data = 16'h0033;
    tick();
    s_data = 16'h0044;
    #1;
    chk("hold_sready", 32'(s_ready), 32'h2);
    chk("hold_mvalid", 32'(m_valid), 32'h0);
    tick();
    s_valid = 2'b11; s_data = 16'h5544;
    #1;
    chk("hold_mvalid_fire", 32'(m_valid), 32'h1);
    chk("hold_mdata", 32'(m_data), 32'h5533);
    tick();
    s_valid = '0;
    #1;
    chk("hold_count", 32'(beat_count), 32'h4);

    // Reset mid-operation
    s_valid = 2'b10; s_data = 16'h9900; m_ready = 1'b0;
    tick();
    s_valid = '0;
    #1;
    chk("mrst_busy_pre", 32'(busy), 32'h1);
    chk("mrst_sready_pre", 32'(s_ready), 32'h1);
    reset = 1'b1; s_valid = 2'b01; m_ready = 1'b1;
    #1;
    chk("mrst_mvalid", 32'(m_valid), 32'h0);
    chk("mrst_sready", 32'(s_ready), 32'h0);
    tick();
    reset = 1'b0; s_valid = '0;
    #1;
    chk("mrst_busy", 32'(busy), 32'h0);
    chk("mrst_count", 32'(beat_count), 32'h0);
    chk("mrst_sready_post", 32'(s_ready), 32'h3);
    s_valid = 2'b01; s_data = 16'h00CD;
    #1;
    chk("mrst_discarded", 32'(m_valid), 32'h0);
    tick();
    s_valid = 2'b10; s_data = 16'hAB00;
    #1;
    chk("mrst_new_mdata", 32'(m_data), 32'hABCD);
    tick();
    s_valid = '0;
    #1;
    chk("mrst_new_count", 32'(beat_count), 32'h1);

    // Counter wrap on the 4-bit instance
    w_s_valid = 2'b11; w_m_ready = 1'b1;
    for (int b = 1; b <= 17; b++) begin
      w_s_data = 16'(b * 16'h0101);
      #1;
      chk("wrap_mvalid", 32'(w_m_valid), 32'h1);
      tick();
      chk("wrap_count", 32'(w_beat_count), 32'(b % 16));
    end
    w_s_valid = '0;
    #1;
    chk("wrap_final", 32'(w_beat_count), 32'h1);
    chk("wrap_busy", 32'(w_busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
